spi_dbg_tx: RTL and testbench

- Byte-stream debug output transmitter. Sits between the core's debug/print MMIO store path and the user IO pads that carry the print SPI lines: clock on pad 4, MOSI on pad 1, CS selectable.
- Buffers bytes in a small FIFO and serialises each one MSB-first onto a write-only SPI link: mode 0, MOSI stable across the rising SCK edge.
- Feeds the off-chip/bench receiver, which shifts MOSI on every rising SCK and emits one character per 8 edges; no framing other than bit count.

---
 rtl/spi_dbg_pkg.sv | 14 +
 rtl/spi_dbg_fifo.sv | 93 +++++++++
 rtl/spi_dbg_tx.sv | 193 +++++++++++++++++++
 tb/tb_spi_dbg_tx.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_dbg_pkg.sv
// spi_dbg_pkg: types and constants shared by the SPI debug transmitter.
//   spi_state_e   : serialiser FSM states (IDLE, LOW, HIGH)
//   SPI_BYTE_BITS : bits per transferred character
package spi_dbg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } spi_state_e;

  localparam int unsigned SPI_BYTE_BITS = 8;

endpackage

// File: rtl/spi_dbg_fifo.sv
// spi_dbg_fifo: byte FIFO between the debug store path and the serialiser.
// Parameters:
//   DEPTH       entries, power of two, >= 2
// Ports:
//   clk         system clock
//   rst         synchronous active-low reset; discards all contents
//   push_valid  byte offered
//   push_data   byte to store
//   push_ready  registered "not full"; a push happens on push_valid & push_ready
//   pop         consumer takes pop_data this cycle (ignored when empty)
//   pop_data    oldest stored byte
//   empty       no bytes stored
//   count       occupancy, 0..DEPTH
module spi_dbg_fifo
  import spi_dbg_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  input  logic [SPI_BYTE_BITS-1:0] push_data,
  output logic                     push_ready,
  input  logic                     pop,
  output logic [SPI_BYTE_BITS-1:0] pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [SPI_BYTE_BITS-1:0] mem_q [DEPTH];
  logic [SPI_BYTE_BITS-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     ready_q, ready_d;

  logic push_fire;
  logic pop_fire;

  assign push_fire = push_valid & ready_q;
  assign pop_fire  = pop & (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push_fire) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_fire) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push_fire, pop_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Ready follows the post-update occupancy, so a pop while full only
    // reopens the input on the following cycle.
    ready_d = (count_d != CNT_FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  assign push_ready = ready_q;
  assign pop_data   = mem_q[rd_ptr_q];
  assign empty      = (count_q == '0);
  assign count      = count_q;

endmodule

// File: rtl/spi_dbg_tx.sv
// spi_dbg_tx: debug byte-stream transmitter onto a write-only SPI link
// (mode 0, MSB first, MOSI changes only with the falling SCK edge or at load).
// Parameters:
//   FIFO_DEPTH   byte entries buffered (power of two, >= 2)
//   CLK_DIV      clk cycles per SCK half-period (>= 1)
// Ports:
//   clk          system clock
//   rst          synchronous active-low reset; aborts any byte in flight
//   IN_valid     byte offered
//   IN_data      byte to send
//   IN_ready     FIFO can accept (registered !full)
//   OUT_spiClk   SCK, idle low
//   OUT_spiMosi  serial data
//   OUT_spiCs    chip select, active low, held low across back-to-back bytes
//   OUT_busy     FIFO non-empty or serialiser active
// Optional build macro SPI_DBG_TX_STATS_EN adds:
//   OUT_byteCnt  16-bit wrapping count of bytes fully shifted out
//   OUT_drop     one-cycle pulse the cycle after IN_valid was refused
module spi_dbg_tx
  import spi_dbg_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CLK_DIV    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       IN_valid,
  input  logic [7:0] IN_data,
  output logic       IN_ready,
  output logic       OUT_spiClk,
  output logic       OUT_spiMosi,
  output logic       OUT_spiCs,
  output logic       OUT_busy
`ifdef SPI_DBG_TX_STATS_EN
  ,
  output logic [15:0] OUT_byteCnt,
  output logic        OUT_drop
`endif
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam int unsigned BIT_W = $clog2(SPI_BYTE_BITS);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SPI_BYTE_BITS - 1);

  logic                          fifo_pop;
  logic [SPI_BYTE_BITS-1:0]      fifo_data;
  logic                          fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  spi_dbg_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (IN_valid),
    .push_data  (IN_data),
    .push_ready (IN_ready),
    .pop        (fifo_pop),
    .pop_data   (fifo_data),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  spi_state_e               state_q, state_d;
  logic                     sck_q, sck_d;
  logic                     mosi_q, mosi_d;
  logic                     cs_q, cs_d;
  logic [SPI_BYTE_BITS-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]         bitcnt_q, bitcnt_d;
  logic [DIV_W-1:0]         divcnt_q, divcnt_d;

  always_comb begin
    state_d  = state_q;
    sck_d    = sck_q;
    mosi_d   = mosi_q;
    cs_d     = cs_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    divcnt_d = divcnt_q;
    fifo_pop = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_data;
          mosi_d   = fifo_data[SPI_BYTE_BITS-1];
          cs_d     = 1'b0;
          sck_d    = 1'b0;
          bitcnt_d = '0;
          divcnt_d = '0;
          state_d  = LOW;
        end
      end

      LOW: begin
        if (divcnt_q == DIV_LAST) begin
          divcnt_d = '0;
          sck_d    = 1'b1;
          state_d  = HIGH;
        end else begin
          divcnt_d = divcnt_q + 1'b1;
        end
      end

      HIGH: begin
        if (divcnt_q == DIV_LAST) begin
          divcnt_d = '0;
          sck_d    = 1'b0;
          if (bitcnt_q != BIT_LAST) begin
            shreg_d  = {shreg_q[SPI_BYTE_BITS-2:0], 1'b0};
            mosi_d   = shreg_q[SPI_BYTE_BITS-2];
            bitcnt_d = bitcnt_q + 1'b1;
            state_d  = LOW;
          end else if (!fifo_empty) begin
            // Chain the next byte on the final falling edge: no CS gap.
            fifo_pop = 1'b1;
            shreg_d  = fifo_data;
            mosi_d   = fifo_data[SPI_BYTE_BITS-1];
            bitcnt_d = '0;
            state_d  = LOW;
          end else begin
            cs_d    = 1'b1;
            mosi_d  = 1'b0;
            state_d = IDLE;
          end
        end else begin
          divcnt_d = divcnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      cs_q     <= 1'b1;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      divcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
      cs_q     <= cs_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      divcnt_q <= divcnt_d;
    end
  end

  assign OUT_spiClk  = sck_q;
  assign OUT_spiMosi = mosi_q;
  assign OUT_spiCs   = cs_q;
  assign OUT_busy    = (state_q != IDLE) | (fifo_count != '0);

`ifdef SPI_DBG_TX_STATS_EN
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic        drop_q, drop_d;
  logic        byte_done;

  always_comb begin
    // A byte counts as sent on its final SCK falling edge.
    byte_done  = (state_q == HIGH) && (divcnt_q == DIV_LAST) &&
                 (bitcnt_q == BIT_LAST);
    byte_cnt_d = byte_done ? (byte_cnt_q + 16'd1) : byte_cnt_q;
    drop_d     = IN_valid & ~IN_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_cnt_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      drop_q     <= drop_d;
    end
  end

  assign OUT_byteCnt = byte_cnt_q;
  assign OUT_drop    = drop_q;
`else
  // Statistics build option disabled: no counter or drop-pulse logic.
`endif

endmodule

// File: tb/tb_spi_dbg_tx.sv
// Testbench for spi_dbg_tx: randomized and directed byte streams, expected
// bytes queued at acceptance, a monitor decoding SCK/MOSI like the off-chip
// receiver and comparing against the queue and link timing rules.
module tb_spi_dbg_tx;

  localparam int unsigned CLK_DIV  = 2;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned BYTE_CYC = 16 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       IN_valid = 1'b0;
  logic [7:0] IN_data = 8'h00;
  logic       IN_ready;
  logic       OUT_spiClk;
  logic       OUT_spiMosi;
  logic       OUT_spiCs;
  logic       OUT_busy;
`ifdef SPI_DBG_TX_STATS_EN
  logic [15:0] OUT_byteCnt;
  logic        OUT_drop;
`endif

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  spi_dbg_tx #(
    .FIFO_DEPTH(DEPTH),
    .CLK_DIV   (CLK_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .IN_valid   (IN_valid),
    .IN_data    (IN_data),
    .IN_ready   (IN_ready),
    .OUT_spiClk (OUT_spiClk),
    .OUT_spiMosi(OUT_spiMosi),
    .OUT_spiCs  (OUT_spiCs),
    .OUT_busy   (OUT_busy)
`ifdef SPI_DBG_TX_STATS_EN
    ,
    .OUT_byteCnt(OUT_byteCnt),
    .OUT_drop   (OUT_drop)
`endif
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0]  exp_q[$];
  logic        p_sck = 1'b0, p_cs = 1'b1, p_mosi = 1'b0;
  int unsigned bits = 0;
  logic [7:0]  sh = 8'h00;
  int unsigned edges_win = 0, fall_cyc = 0, last_edge_cyc = 0;
  int unsigned win_cnt = 0, rx_total = 0;
  logic        drop_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Receiver-side model: shift MOSI on each rising SCK, one char per 8 edges.
  task automatic monitor();
    logic in_shift;
    forever begin
      @(negedge clk);
      if (!rst) begin
        bits      = 0;
        edges_win = 0;
        rx_total  = 0;
        drop_prev = 1'b0;
      end else begin
        if (OUT_spiMosi !== p_mosi)
          check("mosi_change_point", 32'((p_sck && !OUT_spiClk) || (p_cs && !OUT_spiCs)), 1);
        if (p_cs && !OUT_spiCs) begin
          fall_cyc  = cyc;
          edges_win = 0;
          bits      = 0;
        end
        if (OUT_spiClk && !p_sck) begin
          check("cs_low_at_rise", 32'(OUT_spiCs), 0);
          if (edges_win == 0) check("first_rise_latency", cyc - fall_cyc, CLK_DIV);
          else                check("rise_spacing", cyc - last_edge_cyc, 2 * CLK_DIV);
          last_edge_cyc = cyc;
          edges_win++;
          sh = {sh[6:0], OUT_spiMosi};
          bits++;
          if (bits == 8) begin
            bits = 0;
            rx_total++;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_byte: got 0x%02h expected none", sh);
            end else begin
              check("rx_byte", 32'(sh), 32'(exp_q.pop_front()));
            end
          end
        end
        if (!p_cs && OUT_spiCs) begin
          check("cs_window_len", cyc - fall_cyc, (edges_win / 8) * BYTE_CYC);
          check("cs_window_bits", edges_win % 8, 0);
          win_cnt++;
        end
        check("busy", 32'(OUT_busy), 32'(!OUT_spiCs || exp_q.size() != 0));
        // A byte sits in the shifter while CS is low, except between its
        // 8th rising edge and the following fall.
        in_shift = !OUT_spiCs && !(OUT_spiClk && bits == 0);
        check("in_ready", 32'(IN_ready), 32'((exp_q.size() - 32'(in_shift)) < DEPTH));
`ifdef SPI_DBG_TX_STATS_EN
        check("drop_pulse", 32'(OUT_drop), 32'(drop_prev));
        drop_prev = IN_valid && !IN_ready;
`endif
      end
      p_sck  = OUT_spiClk;
      p_cs   = OUT_spiCs;
      p_mosi = OUT_spiMosi;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 one cycle later.
  task automatic send_cycle(input logic v, input logic [7:0] d, output logic acc);
    IN_valid = v;
    IN_data  = d;
    @(negedge clk);
    acc = v && IN_ready && rst;
    @(posedge clk);
    if (acc) exp_q.push_back(d);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n = 0;
    while (!(OUT_spiCs && !OUT_busy && exp_q.size() == 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({"idle_", tag}, 32'(n < 2000), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rises(input int unsigned target);
    int unsigned n = 0;
    logic prev;
    prev = OUT_spiClk;
    for (int c = 0; c < 1000 && n < target; c++) begin
      @(negedge clk);
      if (OUT_spiClk && !prev) n++;
      prev = OUT_spiClk;
    end
    check("rise_wait", n, target);
  endtask

  initial begin
    logic        acc;
    int unsigned w0, r0, idx, n;
    int          stall_at;
    logic [7:0]  six [6];

    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sck", 32'(OUT_spiClk), 0);
    check("rst_mosi", 32'(OUT_spiMosi), 0);
    check("rst_cs", 32'(OUT_spiCs), 1);
    check("rst_busy", 32'(OUT_busy), 0);
    check("rst_ready", 32'(IN_ready), 1);
`ifdef SPI_DBG_TX_STATS_EN
    check("rst_bytecnt", 32'(OUT_byteCnt), 0);
    check("rst_drop", 32'(OUT_drop), 0);
`endif
    @(posedge clk);
    #1 rst = 1'b1;

    // Single 'A'
    w0 = win_cnt; r0 = rx_total;
    send_cycle(1'b1, 8'h41, acc);
    IN_valid = 1'b0;
    wait_idle("single");
    check("single_windows", win_cnt - w0, 1);
    check("single_bytes", rx_total - r0, 1);

    // "Hi" back to back
    w0 = win_cnt; r0 = rx_total;
    send_cycle(1'b1, 8'h48, acc);
    send_cycle(1'b1, 8'h69, acc);
    IN_valid = 1'b0;
    wait_idle("hi");
    check("hi_windows", win_cnt - w0, 1);
    check("hi_bytes", rx_total - r0, 2);

    // Six bytes with IN_valid held: fills FIFO, then resumes after pops.
    foreach (six[i]) six[i] = 8'($urandom);
    idx = 0; stall_at = -1;
    for (int c = 0; c < 400 && idx < 6; c++) begin
      send_cycle(1'b1, six[idx], acc);
      if (acc) idx++;
      else if (stall_at < 0) stall_at = int'(idx);
    end
    IN_valid = 1'b0;
    check("accepts_before_full", 32'(stall_at), 5);
    check("all_six_accepted", idx, 6);
    wait_idle("six");

    // Reset at the 3rd rising edge of 0xA5 with two bytes queued.
    send_cycle(1'b1, 8'hA5, acc);
    send_cycle(1'b1, 8'h5A, acc);
    send_cycle(1'b1, 8'hC3, acc);
    IN_valid = 1'b0;
    wait_rises(3);
    #2 rst = 1'b0;
    @(posedge clk);
    exp_q.delete();
    @(negedge clk);
    check("abort_sck", 32'(OUT_spiClk), 0);
    check("abort_cs", 32'(OUT_spiCs), 1);
    check("abort_mosi", 32'(OUT_spiMosi), 0);
    check("abort_busy", 32'(OUT_busy), 0);
    check("abort_ready", 32'(IN_ready), 1);
    @(posedge clk);
    #1 rst = 1'b1;
    n = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (OUT_spiClk || !OUT_spiCs) n++;
    end
    check("abort_no_activity", n, 0);
    @(posedge clk);
    #1;

    // Push while the last bit of the previous byte is high.
    send_cycle(1'b1, 8'h3C, acc);
    IN_valid = 1'b0;
    w0 = win_cnt;
    wait_rises(8);
    #1;
    IN_valid = 1'b1;
    IN_data  = 8'hC3;
    acc = IN_ready;
    @(posedge clk);
    if (acc) exp_q.push_back(8'hC3);
    #1 IN_valid = 1'b0;
    check("lastbit_accept", 32'(acc), 1);
    wait_idle("lastbit");
    check("lastbit_no_cs_gap", win_cnt - w0, 1);

    // Randomized bursts with random valid gaps and idle spacing.
    for (int r = 0; r < 24; r++) begin
      n = $urandom_range(1, 9);
      for (int i = 0; i < int'(n); i++)
        send_cycle(($urandom_range(0, 3) != 0), 8'($urandom), acc);
      IN_valid = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        wait_idle("rand");
      end else begin
        repeat ($urandom_range(0, 40)) @(posedge clk);
        #1;
      end
    end
    wait_idle("final");
`ifdef SPI_DBG_TX_STATS_EN
    check("byte_count", 32'(OUT_byteCnt), rx_total & 32'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
